// File: rtl/iter_addsub_if.sv
// Start/done handshake and result bundle for the iterative add/subtract unit.
// The requester drives operands and start; the unit returns busy/done, result and flags.
interface iter_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ALUFun0;
  logic             Sign;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Zero;
  logic             Overflow;
  logic             Negative;

  modport master (
    output start, A, B, ALUFun0, Sign,
    input  busy, done, S, Zero, Overflow, Negative
  );

  modport slave (
    input  start, A, B, ALUFun0, Sign,
    output busy, done, S, Zero, Overflow, Negative
  );
endinterface

// File: rtl/iter_addsub.sv
// Multi-cycle add/subtract producing S plus Zero/Overflow/Negative for the compare stage.
// Operands are processed CHUNK bits per cycle, least significant chunk first.
module iter_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic         clk,
  input logic         reset,
  iter_addsub_if.slave bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] a_q,       a_d;
  logic [WIDTH-1:0] b_q,       b_d;
  logic [WIDTH-1:0] s_q,       s_d;
  logic             sub_q,     sub_d;
  logic             sign_q,    sign_d;
  logic             carry_q,   carry_d;
  logic             nonzero_q, nonzero_d;
  logic             zero_q,    zero_d;
  logic             ovf_q,     ovf_d;
  logic             neg_q,     neg_d;
  logic [IDX_W-1:0] idx_q,     idx_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic             chunk_cout;
  logic             msb_cin;
  logic             last_chunk;
  logic             accept;

  // One chunk of the ripple; subtraction is A + ~B with the +1 entering as carry-in.
  always_comb begin
    a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk = sub_q ? ~b_q[idx_q*CHUNK +: CHUNK] : b_q[idx_q*CHUNK +: CHUNK];
    {chunk_cout, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the chunk MSB recovered from the MSB sum bit, avoiding a split adder.
    msb_cin = sum_chunk[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
  end

  assign accept     = bus.start && (state_q != ST_RUN);
  assign last_chunk = (idx_q == IDX_W'(N - 1));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    sub_d     = sub_q;
    sign_d    = sign_q;
    carry_d   = carry_q;
    nonzero_d = nonzero_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    neg_d     = neg_q;
    idx_d     = idx_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d   = ST_RUN;
          a_d       = bus.A;
          b_d       = bus.B;
          sub_d     = bus.ALUFun0;
          sign_d    = bus.Sign;
          carry_d   = bus.ALUFun0;
          nonzero_d = 1'b0;
          idx_d     = '0;
        end
      end

      ST_RUN: begin
        s_d[idx_q*CHUNK +: CHUNK] = sum_chunk;
        carry_d   = chunk_cout;
        nonzero_d = nonzero_q | (|sum_chunk);
        idx_d     = idx_q + IDX_W'(1);
        if (last_chunk) begin
          state_d = ST_DONE;
          idx_d   = '0;
          zero_d  = ~(nonzero_q | (|sum_chunk));
          if (sign_q) begin
            ovf_d = msb_cin ^ chunk_cout;
            neg_d = sum_chunk[CHUNK-1];
          end else if (sub_q) begin
            ovf_d = 1'b0;
            neg_d = ~chunk_cout;
          end else begin
            ovf_d = chunk_cout;
            neg_d = 1'b0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      sub_q     <= 1'b0;
      sign_q    <= 1'b0;
      carry_q   <= 1'b0;
      nonzero_q <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      s_q       <= s_d;
      sub_q     <= sub_d;
      sign_q    <= sign_d;
      carry_q   <= carry_d;
      nonzero_q <= nonzero_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      neg_q     <= neg_d;
      idx_q     <= idx_d;
    end
  end

  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.S        = s_q;
  assign bus.Zero     = zero_q;
  assign bus.Overflow = ovf_q;
  assign bus.Negative = neg_q;

endmodule
